mod_mem_stall: RTL and testbench

//   Parametrised multi-cycle memory-access stage. Replaces the single-cycle MEM

---
 rtl/mod_mem_stall.sv | 129 ++++++++++++
 tb/tb_mod_mem_stall.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_mem_stall.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mod_mem_stall : multi-cycle MEM stage, fixed-latency data array + stall   |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mod_mem_stall #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memenable,
  input  logic              memwrite,
  input  logic              forward_mm,
  input  logic [DATA_W-1:0] memdata,
  input  logic [DATA_W-1:0] memdata_forward,
  input  logic [ADDR_W-1:0] addr,
  output logic              stall,
  output logic [DATA_W-1:0] mem_out
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0]     mem [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] op_idx_q, op_idx_d;
  logic [DATA_W-1:0]     op_wdata_q, op_wdata_d;
  logic                  op_write_q, op_write_d;
  logic [DATA_W-1:0]     mem_out_q, mem_out_d;

  logic [DEPTH_LOG2-1:0] live_idx;
  logic [DATA_W-1:0]     live_wdata;
  logic                  ready;
  logic                  commit;
  logic [DEPTH_LOG2-1:0] commit_idx;
  logic [DATA_W-1:0]     commit_wdata;
  logic                  commit_write;
  logic                  mem_we;

  // Byte address: bit 0 dropped, bits above the array index alias.
  assign live_idx   = addr[DEPTH_LOG2:1];
  assign live_wdata = forward_mm ? memdata_forward : memdata;

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr[0], addr[ADDR_W-1:DEPTH_LOG2+1]};

  assign ready = (LATENCY == 1) || ((state_q == BUSY) && (cnt_q == CNT_ONE));
  assign stall = memenable && !ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_idx_d     = op_idx_q;
    op_wdata_d   = op_wdata_q;
    op_write_d   = op_write_q;
    commit       = 1'b0;
    commit_idx   = op_idx_q;
    commit_wdata = op_wdata_q;
    commit_write = op_write_q;

    if (LATENCY == 1) begin
      commit       = memenable;
      commit_idx   = live_idx;
      commit_wdata = live_wdata;
      commit_write = memwrite;
    end else if (state_q == IDLE) begin
      if (memenable) begin
        op_idx_d   = live_idx;
        op_wdata_d = live_wdata;
        op_write_d = memwrite;
        cnt_d      = CNT_LOAD;
        state_d    = BUSY;
      end
    end else if (!memenable) begin
      // Squashed instruction: abandon the access without touching the array.
      state_d = IDLE;
      cnt_d   = '0;
    end else if (cnt_q == CNT_ONE) begin
      commit  = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q - CNT_ONE;
    end

    mem_out_d = (commit && !commit_write) ? mem[commit_idx] : mem_out_q;
  end

  assign mem_we = commit && commit_write && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_idx_q   <= '0;
      op_wdata_q <= '0;
      op_write_q <= 1'b0;
      mem_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_idx_q   <= op_idx_d;
      op_wdata_q <= op_wdata_d;
      op_write_q <= op_write_d;
      mem_out_q  <= mem_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[commit_idx] <= commit_wdata;
    end
  end

  assign mem_out = mem_out_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_mem_stall.sv
`default_nettype none
// tb_mod_mem_stall : vector table, directed corner cases and a random run
// against a transaction-level model, for LATENCY=4 and LATENCY=1 instances.
module tb_mod_mem_stall;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        wr  = 1'b0;
  logic        fwd = 1'b0;
  logic [15:0] md  = '0;
  logic [15:0] mdf = '0;
  logic [15:0] a   = '0;
  logic        stall4, stall1;
  logic [15:0] mo4, mo1;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  mod_mem_stall #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(4)) u4 (
    .clk(clk), .rst(rst), .memenable(en), .memwrite(wr), .forward_mm(fwd),
    .memdata(md), .memdata_forward(mdf), .addr(a), .stall(stall4), .mem_out(mo4)
  );

  mod_mem_stall #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .memenable(en), .memwrite(wr), .forward_mm(fwd),
    .memdata(md), .memdata_forward(mdf), .addr(a), .stall(stall1), .mem_out(mo1)
  );

  typedef struct {
    logic        en, wr, fwd;
    logic [15:0] md, mdf, a;
    logic        xs;
    logic [15:0] xmo;
  } vec_t;

  vec_t vt [16];

  // Transaction-level reference: an access accepted at age 0 completes at age LAT-1.
  logic [15:0] m_mem [1024];
  bit          m_val [1024];
  bit          pend;
  int          age;
  logic [9:0]  p_idx;
  logic [15:0] p_wd;
  bit          p_wr;
  logic [15:0] m_mo;
  bit          m_known;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step(input bit sel, input logic e, input logic w, input logic f,
                      input logic [15:0] d, input logic [15:0] df, input logic [15:0] ad,
                      input logic xs, input logic [15:0] xmo, input bit chk_mo,
                      input string nm);
    en = e; wr = w; fwd = f; md = d; mdf = df; a = ad;
    #1;
    chk({nm, " stall"}, {15'b0, sel ? stall1 : stall4}, {15'b0, xs});
    @(posedge clk);
    #1;
    if (chk_mo) chk({nm, " mem_out"}, sel ? mo1 : mo4, xmo);
  endtask

  task automatic acc4(input logic w, input logic f, input logic [15:0] d,
                      input logic [15:0] df, input logic [15:0] ad,
                      input logic [15:0] prev_mo, input logic [15:0] new_mo,
                      input string nm);
    for (int k = 0; k < 4; k++)
      step(1'b0, 1'b1, w, f, d, df, ad, (k < 3), (k < 3) ? prev_mo : new_mo, 1'b1, nm);
  endtask

  task automatic model_step(input logic e, input logic w, input logic f,
                            input logic [15:0] d, input logic [15:0] df,
                            input logic [15:0] ad, input int lat, output logic xs);
    if (!e) begin
      pend = 1'b0;
      xs   = 1'b0;
    end else begin
      if (!pend) begin
        pend  = 1'b1;
        age   = 0;
        p_idx = ad[10:1];
        p_wd  = f ? df : d;
        p_wr  = w;
      end else begin
        age++;
      end
      xs = (age < lat - 1);
      if (age == lat - 1) begin
        pend = 1'b0;
        if (p_wr) begin
          m_mem[p_idx] = p_wd;
          m_val[p_idx] = 1'b1;
        end else if (m_val[p_idx]) begin
          m_mo    = m_mem[p_idx];
          m_known = 1'b1;
        end else begin
          m_known = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic        e, w, f, xs;
    logic [15:0] d, df, ad;

    // Store BEEF @0x10 then load it; forwarded store 1234 @0x20 then load it.
    vt[0]  = '{1'b1, 1'b1, 1'b0, 16'hBEEF, 16'h0000, 16'h0010, 1'b1, 16'h0000};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 16'hBEEF, 16'h0000, 16'h0010, 1'b1, 16'h0000};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 16'hBEEF, 16'h0000, 16'h0010, 1'b1, 16'h0000};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 16'hBEEF, 16'h0000, 16'h0010, 1'b0, 16'h0000};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 1'b1, 16'h0000};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 1'b1, 16'h0000};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 1'b1, 16'h0000};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 1'b0, 16'hBEEF};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 16'h5555, 16'h1234, 16'h0020, 1'b1, 16'hBEEF};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 16'h5555, 16'h1234, 16'h0020, 1'b1, 16'hBEEF};
    vt[10] = '{1'b1, 1'b1, 1'b1, 16'h5555, 16'h1234, 16'h0020, 1'b1, 16'hBEEF};
    vt[11] = '{1'b1, 1'b1, 1'b1, 16'h5555, 16'h1234, 16'h0020, 1'b0, 16'hBEEF};
    vt[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0020, 1'b1, 16'hBEEF};
    vt[13] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0020, 1'b1, 16'hBEEF};
    vt[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0020, 1'b1, 16'hBEEF};
    vt[15] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0020, 1'b0, 16'h1234};

    @(posedge clk);
    #1;
    chk("reset stall", {15'b0, stall4}, 16'h0000);
    chk("reset mem_out lat4", mo4, 16'h0000);
    chk("reset mem_out lat1", mo1, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      step(1'b0, vt[i].en, vt[i].wr, vt[i].fwd, vt[i].md, vt[i].mdf, vt[i].a,
           vt[i].xs, vt[i].xmo, 1'b1, $sformatf("vec%0d", i));

    // Operands captured at acceptance; later changes are ignored.
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h5555, 16'h1234, 16'h0040, 1'b1, 16'h1234, 1'b1, "capture");
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h6666, 16'hFFFF, 16'h0050, 1'b1, 16'h1234, 1'b1, "capture");
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h6666, 16'hFFFF, 16'h0050, 1'b1, 16'h1234, 1'b1, "capture");
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h6666, 16'hFFFF, 16'h0050, 1'b0, 16'h1234, 1'b1, "capture");
    acc4(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 16'h1234, 16'hBEEF, "ld10");
    acc4(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0040, 16'hBEEF, 16'h1234, "ld40");

    // Squash in the second busy cycle leaves the old value in place.
    acc4(1'b1, 1'b0, 16'h1111, 16'h0000, 16'h0030, 16'h1234, 16'h1234, "st30");
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'hAAAA, 16'h0000, 16'h0030, 1'b1, 16'h1234, 1'b1, "squash");
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'hAAAA, 16'h0000, 16'h0030, 1'b0, 16'h1234, 1'b1, "squash");
    acc4(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0030, 16'h1234, 16'h1111, "ld30");

    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h9999, 16'h9999, 16'h0010, 1'b0, 16'h1111, 1'b1, "wr_no_en");

    // Asynchronous reset in the middle of a load.
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 1'b1, 16'h1111, 1'b1, "rst_mid");
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 1'b1, 16'h1111, 1'b1, "rst_mid");
    en  = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid stall", {15'b0, stall4}, 16'h0000);
    chk("rst_mid mem_out", mo4, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    acc4(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'hBEEF, "after_rst");

    pend    = 1'b0;
    age     = 0;
    m_mo    = 16'hBEEF;
    m_known = 1'b1;
    for (int i = 0; i < 400; i++) begin
      e  = ($urandom_range(99) < 85);
      w  = 1'($urandom_range(1));
      f  = 1'($urandom_range(1));
      d  = 16'($urandom);
      df = 16'($urandom);
      ad = {5'($urandom), 7'b0, 3'($urandom_range(7)), 1'($urandom_range(1))};
      model_step(e, w, f, d, df, ad, 4, xs);
      step(1'b0, e, w, f, d, df, ad, xs, m_mo, m_known, "rand");
    end

    // Single-cycle instance: back-to-back store/load, plus 0x0800 aliasing to 0x0000.
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h7777, 16'h0000, 16'h0800, 1'b0, 16'h0000, 1'b0, "l1 st");
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h7777, 1'b1, "l1 ld");
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'hA1A1, 16'h0000, 16'h0002, 1'b0, 16'h7777, 1'b1, "l1 st");
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0003, 1'b0, 16'hA1A1, 1'b1, "l1 ld");
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'hB2B2, 16'h0004, 1'b0, 16'hA1A1, 1'b1, "l1 st");
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0804, 1'b0, 16'hB2B2, 1'b1, "l1 ld");
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0800, 1'b0, 16'h7777, 1'b1, "l1 ld");
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h4444, 16'h0000, 16'h0000, 1'b0, 16'h7777, 1'b1, "l1 idle");
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h7777, 1'b1, "l1 ld");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
